minbd_side_buffer: RTL

- Side buffer for the MinBD deflection router.
- Captures flits that the ejection/deflection stage pulls out of the pipeline and stores them in a circular FIFO.
- Reinjects the head flit whenever the router pipeline reports a free slot.
- Raises a redirect request when the buffer stays full long enough to risk livelock. Router control uses that request to force a buffer write on the next deflected flit.
- Sits between the deflection-arbitration stage (write side) and the reinjection mux (read side). It is the consumer/producer counterpart of the router's pipeline registers.

---
 rtl/minbd_side_buffer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/minbd_side_buffer.sv
// MinBD side buffer: a circular FIFO that captures flits pulled out of the
// router pipeline and reinjects the head flit whenever the pipeline reports
// a free slot. A full-duration timer raises redirect_req when the buffer has
// been full long enough to risk livelock.
module minbd_side_buffer #(
   parameter int unsigned FLIT_W       = 64,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned REDIR_THRESH = 8,
   localparam int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   input  logic [FLIT_W-1:0] wr_flit,
   output logic              wr_ready,
   input  logic              slot_free,
   output logic              rd_valid,
   output logic [FLIT_W-1:0] rd_flit,
   output logic              rd_pop,
   output logic [CNT_W-1:0]  count,
   output logic              redirect_req,
   output logic              overflow_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   // Timer only needs to reach REDIR_THRESH, where it saturates.
   localparam int unsigned TMR_W = $clog2(REDIR_THRESH + 1);

   logic [FLIT_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [TMR_W-1:0] full_cnt_q, full_cnt_d;
   logic             overflow_q, overflow_d;

   logic full;
   logic empty;
   logic push;
   logic pop;

   // Status flags and handshake decode from registered occupancy.
   always_comb begin
      full  = (count_q == CNT_W'(DEPTH));
      empty = (count_q == '0);
      // Push is gated by the registered full flag, so a simultaneous pop
      // while full cannot make room for a write in the same cycle.
      push  = wr_valid & ~full;
      pop   = ~empty & slot_free;
   end

   // Next-state for pointers, occupancy, full timer and sticky overflow.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      full_cnt_d = full_cnt_q;
      overflow_d = overflow_q;

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (!full) begin
         full_cnt_d = '0;
      end else if (full_cnt_q != TMR_W'(REDIR_THRESH)) begin
         full_cnt_d = full_cnt_q + TMR_W'(1);
      end

      if (wr_valid && full) begin
         overflow_d = 1'b1;
      end
   end

   // Control state register with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_cnt_q <= full_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage array; contents are deliberately not reset, and writes are
   // blocked while reset is held so an offered flit is never captured.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr_q] <= wr_flit;
      end
   end

   // Output drive; read data is show-ahead from the head entry.
   always_comb begin
      wr_ready     = ~full;
      rd_valid     = ~empty;
      rd_flit      = mem[rd_ptr_q];
      rd_pop       = pop;
      count        = count_q;
      redirect_req = (full_cnt_q == TMR_W'(REDIR_THRESH));
      overflow_err = overflow_q;
   end

endmodule
